// File: rtl/sp_ram_be_if.sv
// Bus-side interface of sp_ram_be: req/ready access channel, clear request and response.
// The master drives requests; the slave (the RAM) returns ready, data and status.
interface sp_ram_be_if #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 32
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic               req;
  logic               w_en;
  logic [WIDTH/8-1:0] be;
  logic [AW-1:0]      addr;
  logic [WIDTH-1:0]   data_in;
  logic               clr;
  logic               ready;
  logic [WIDTH-1:0]   data_out;
  logic               rd_valid;
  logic               init_done;

  modport master (
    output req, w_en, be, addr, data_in, clr,
    input  ready, data_out, rd_valid, init_done
  );

  modport slave (
    input  req, w_en, be, addr, data_in, clr,
    output ready, data_out, rd_valid, init_done
  );
endinterface

// File: rtl/sp_ram_be.sv
// Single-port RAM with byte enables, req/ready handshake and an init sweep after reset/clr.
// Define SP_RAM_BE_OUTREG_EN to add a second output register stage (latency 2).
module sp_ram_be #(
  parameter int unsigned      DEPTH    = 16,
  parameter int unsigned      WIDTH    = 32,
  parameter int unsigned      RDW_MODE = 0,
  parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
  input logic        clk,
  input logic        rst_n,
  sp_ram_be_if.slave bus
);
  localparam int unsigned   AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned   NB      = WIDTH / 8;
  localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e           state_q;
  logic [AW-1:0]    cnt_q;
  logic             init_done_q;
  logic             rsp_valid_q;
  logic [WIDTH-1:0] rsp_data_q;

  logic [WIDTH-1:0] mem [DEPTH];

  logic             accept;
  logic             addr_ok;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] old_word;
  logic [WIDTH-1:0] merged;
  logic [WIDTH-1:0] rsp_data;

  // clr wins over a same-cycle request
  assign bus.ready = (state_q == StRun) && !bus.clr;
  assign accept    = bus.req && bus.ready;
  assign addr_ok   = 32'(bus.addr) < DEPTH;

  always_comb begin
    old_word = '0;
    if (addr_ok) begin
      old_word = mem[bus.addr];
    end
  end

  always_comb begin
    merged = old_word;
    for (int i = 0; i < int'(NB); i++) begin
      if (bus.be[i]) begin
        merged[8*i +: 8] = bus.data_in[8*i +: 8];
      end
    end
  end

  // Out-of-range addresses always return zero, for reads and writes alike
  always_comb begin
    rsp_data = '0;
    if (addr_ok) begin
      rsp_data = (bus.w_en && (RDW_MODE == 1)) ? merged : old_word;
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    if (state_q == StInit) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wdata = INIT_VAL;
    end else if (accept && bus.w_en && addr_ok) begin
      mem_we    = 1'b1;
      mem_waddr = bus.addr;
      mem_wdata = merged;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StInit;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= accept;
      if (accept) begin
        rsp_data_q <= rsp_data;
      end
      unique case (state_q)
        StInit: begin
          if (bus.clr) begin
            cnt_q <= '0;
          end else if (cnt_q == LastIdx) begin
            cnt_q       <= '0;
            state_q     <= StRun;
            init_done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + AW'(1);
          end
        end
        StRun: begin
          if (bus.clr) begin
            cnt_q       <= '0;
            state_q     <= StInit;
            init_done_q <= 1'b0;
          end
        end
        default: begin
          state_q <= StInit;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.init_done = init_done_q;

`ifdef SP_RAM_BE_OUTREG_EN
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;

  // Not flushed by clr: an in-flight response still emerges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= rsp_valid_q;
      if (rsp_valid_q) begin
        out_data_q <= rsp_data_q;
      end
    end
  end

  assign bus.rd_valid = out_valid_q;
  assign bus.data_out = out_data_q;
`else
  assign bus.rd_valid = rsp_valid_q;
  assign bus.data_out = rsp_data_q;
`endif

endmodule

// File: tb/tb_sp_ram_be.sv
// Directed bench: three sp_ram_be instances (read-before-write, write-first, DEPTH=12)
// share one stimulus stream; each has its own hand-computed expectations.
module tb_sp_ram_be;
`ifdef SP_RAM_BE_OUTREG_EN
  localparam int unsigned Lat = 2;
`else
  localparam int unsigned Lat = 1;
`endif
  localparam logic [31:0] Iv = 32'hA5A5A5A5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        w_en;
  logic        clr;
  logic [3:0]  be;
  logic [3:0]  addr;
  logic [31:0] data_in;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sp_ram_be_if #(.DEPTH(16), .WIDTH(32)) if_a ();
  sp_ram_be_if #(.DEPTH(16), .WIDTH(32)) if_b ();
  sp_ram_be_if #(.DEPTH(12), .WIDTH(32)) if_c ();

  assign if_a.req = req;  assign if_a.w_en = w_en;  assign if_a.be = be;
  assign if_a.addr = addr;  assign if_a.data_in = data_in;  assign if_a.clr = clr;
  assign if_b.req = req;  assign if_b.w_en = w_en;  assign if_b.be = be;
  assign if_b.addr = addr;  assign if_b.data_in = data_in;  assign if_b.clr = clr;
  assign if_c.req = req;  assign if_c.w_en = w_en;  assign if_c.be = be;
  assign if_c.addr = addr;  assign if_c.data_in = data_in;  assign if_c.clr = clr;

  sp_ram_be #(.DEPTH(16), .WIDTH(32), .RDW_MODE(0), .INIT_VAL(32'h0)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(if_a)
  );
  sp_ram_be #(.DEPTH(16), .WIDTH(32), .RDW_MODE(1), .INIT_VAL(Iv)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(if_b)
  );
  sp_ram_be #(.DEPTH(12), .WIDTH(32), .RDW_MODE(0), .INIT_VAL(Iv)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(if_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Issue one access, then wait until its response is on the outputs
  task automatic access(input logic w, input logic [3:0] a, input logic [31:0] d,
                        input logic [3:0] b);
    req = 1'b1; w_en = w; addr = a; data_in = d; be = b;
    cyc();
    req = 1'b0;
    repeat (Lat - 1) cyc();
  endtask

  // Sweep has just started from address 0: A/B take 16 cycles, C takes 12
  task automatic sweep_check(input string tag);
    for (int i = 0; i < 16; i++) begin
      chk({tag, "_a_init_done"}, 32'(if_a.init_done), 32'(0));
      chk({tag, "_b_ready"}, 32'(if_b.ready), 32'(0));
      chk({tag, "_c_init_done"}, 32'(if_c.init_done), (i >= 12) ? 32'(1) : 32'(0));
      cyc();
    end
    chk({tag, "_a_done"}, 32'(if_a.init_done), 32'(1));
    chk({tag, "_b_done"}, 32'(if_b.init_done), 32'(1));
    chk({tag, "_a_ready"}, 32'(if_a.ready), 32'(1));
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < 16; i++) begin
      access(1'b0, 4'(i), 32'h0, 4'h0);
      chk({tag, "_a"}, if_a.data_out, 32'h0);
      chk({tag, "_b"}, if_b.data_out, Iv);
      chk({tag, "_c"}, if_c.data_out, (i < 12) ? Iv : 32'h0);
    end
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; w_en = 1'b0; clr = 1'b0;
    be = 4'h0; addr = 4'h0; data_in = 32'h0;
    repeat (2) cyc();
    chk("rst_data_out", if_a.data_out, 32'h0);
    chk("rst_rd_valid", 32'(if_a.rd_valid), 32'(0));
    chk("rst_init_done", 32'(if_b.init_done), 32'(0));
    chk("rst_ready", 32'(if_c.ready), 32'(0));

    rst_n = 1'b1;
    sweep_check("sweep0");
    read_all("init_read");

    // Write then read the same address on the very next cycle
    req = 1'b1; w_en = 1'b1; addr = 4'd3; data_in = 32'hDEADBEEF; be = 4'hF;
    cyc();
    w_en = 1'b0;
    cyc();
    req = 1'b0;
    repeat (Lat - 1) cyc();
    chk("wr_rd_a", if_a.data_out, 32'hDEADBEEF);
    chk("wr_rd_c", if_c.data_out, 32'hDEADBEEF);
    chk("wr_rd_valid", 32'(if_b.rd_valid), 32'(1));
    cyc();
    chk("idle_valid", 32'(if_a.rd_valid), 32'(0));
    chk("idle_hold", if_a.data_out, 32'hDEADBEEF);

    // Byte-enable merge
    access(1'b1, 4'd5, 32'h11223344, 4'hF);
    chk("full_wr_b", if_b.data_out, 32'h11223344);
    access(1'b1, 4'd5, 32'hAABBCCDD, 4'b0101);
    chk("be_wr_a_old", if_a.data_out, 32'h11223344);
    chk("be_wr_b_new", if_b.data_out, 32'h11BB33DD);
    chk("be_wr_c_old", if_c.data_out, 32'h11223344);
    chk("be_wr_valid", 32'(if_a.rd_valid), 32'(1));
    access(1'b0, 4'd5, 32'h0, 4'h0);
    chk("be_rd_a", if_a.data_out, 32'h11BB33DD);
    chk("be_rd_b", if_b.data_out, 32'h11BB33DD);

    // be = 0 write: nothing changes, response still pulses
    access(1'b1, 4'd5, 32'h00000000, 4'h0);
    chk("be0_a", if_a.data_out, 32'h11BB33DD);
    chk("be0_b", if_b.data_out, 32'h11BB33DD);
    chk("be0_valid", 32'(if_c.rd_valid), 32'(1));
    access(1'b0, 4'd5, 32'h0, 4'h0);
    chk("be0_rd_a", if_a.data_out, 32'h11BB33DD);

    // Address beyond DEPTH on the 12-word instance
    access(1'b1, 4'd13, 32'hFFFFFFFF, 4'hF);
    chk("oor_wr_a", if_a.data_out, 32'h0);
    chk("oor_wr_b", if_b.data_out, 32'hFFFFFFFF);
    chk("oor_wr_c", if_c.data_out, 32'h0);
    chk("oor_wr_valid", 32'(if_c.rd_valid), 32'(1));
    access(1'b0, 4'd13, 32'h0, 4'h0);
    chk("oor_rd_a", if_a.data_out, 32'hFFFFFFFF);
    chk("oor_rd_c", if_c.data_out, 32'h0);
    chk("oor_rd_valid", 32'(if_c.rd_valid), 32'(1));
    access(1'b0, 4'd11, 32'h0, 4'h0);
    chk("last_rd_c", if_c.data_out, Iv);

    // clr together with req: not accepted, sweep reruns
    clr = 1'b1; req = 1'b1; w_en = 1'b1; addr = 4'd3; data_in = 32'h12345678; be = 4'hF;
    #1;
    chk("clr_ready_a", 32'(if_a.ready), 32'(0));
    chk("clr_ready_c", 32'(if_c.ready), 32'(0));
    cyc();
    clr = 1'b0; req = 1'b0;
    chk("clr_no_valid", 32'(if_a.rd_valid), 32'(0));
    sweep_check("sweep_clr");
    read_all("clr_read");

    // Reset in the middle of a sweep
    access(1'b1, 4'd5, 32'hCAFEF00D, 4'hF);
    access(1'b0, 4'd5, 32'h0, 4'h0);
    chk("pre_rst_a", if_a.data_out, 32'hCAFEF00D);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    repeat (7) cyc();
    chk("mid_sweep_hold", if_a.data_out, 32'hCAFEF00D);
    chk("mid_sweep_done", 32'(if_a.init_done), 32'(0));
    rst_n = 1'b0;
    #1;
    chk("async_rst_data", if_a.data_out, 32'h0);
    chk("async_rst_valid", 32'(if_b.rd_valid), 32'(0));
    cyc();
    rst_n = 1'b1;
    sweep_check("sweep_rst");
    access(1'b0, 4'd5, 32'h0, 4'h0);
    chk("post_rst_a", if_a.data_out, 32'h0);
    chk("post_rst_b", if_b.data_out, Iv);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
